// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver with
// anti-ghost blanking and a per-frame data latch.
module seg7_scan #(
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clkin,
   input  logic        rst,
   input  logic        scan_clk,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n
);

   localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } state_t;

   state_t       state_q;
   logic [1:0]   idx_q;
   logic [CW-1:0] cnt_q;
   logic         scan_prev_q;
   logic [15:0]  shadow_val_q;
   logic [3:0]   shadow_dp_q;
   logic         shadow_lz_q;
   logic [3:0]   an_q;
   logic [6:0]   seg_q;
   logic         dpn_q;

   logic         scan_ev;
   logic [1:0]   idx_d;
   logic [3:0]   nib;
   logic         lz_hit;
   logic [3:0]   an_d;
   logic [6:0]   seg_d;
   logic         dpn_d;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      unique case (n)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         4'hF: g = 7'b0001110;
      endcase
      return g;
   endfunction

   always_comb begin
      scan_ev = scan_clk & ~scan_prev_q;
      idx_d   = idx_q + 2'd1;
      nib     = 4'h0;
      lz_hit  = 1'b0;
      // a digit blanks only if it and every digit to its left are zero
      unique case (idx_q)
         2'd0: begin
            nib    = shadow_val_q[3:0];
            lz_hit = 1'b0;
         end
         2'd1: begin
            nib    = shadow_val_q[7:4];
            lz_hit = (shadow_val_q[15:4] == 12'h000);
         end
         2'd2: begin
            nib    = shadow_val_q[11:8];
            lz_hit = (shadow_val_q[15:8] == 8'h00);
         end
         2'd3: begin
            nib    = shadow_val_q[15:12];
            lz_hit = (shadow_val_q[15:12] == 4'h0);
         end
      endcase
      an_d  = ~(4'b0001 << idx_q);
      seg_d = (shadow_lz_q && lz_hit) ? 7'h7F : glyph(nib);
      dpn_d = ~shadow_dp_q[idx_q];
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd3;
         cnt_q        <= '0;
         scan_prev_q  <= 1'b0;
         shadow_val_q <= 16'h0000;
         shadow_dp_q  <= 4'h0;
         shadow_lz_q  <= 1'b0;
         an_q         <= 4'hF;
         seg_q        <= 7'h7F;
         dpn_q        <= 1'b1;
      end else begin
         scan_prev_q <= scan_clk;
         unique case (state_q)
            IDLE, SHOW: begin
               if (scan_ev) begin
                  state_q <= BLANK;
                  idx_q   <= idx_d;
                  cnt_q   <= CNT_LOAD;
                  an_q    <= 4'hF;
                  seg_q   <= 7'h7F;
                  dpn_q   <= 1'b1;
                  if (idx_q == 2'd3) begin
                     shadow_val_q <= value;
                     shadow_dp_q  <= dp;
                     shadow_lz_q  <= blank_lz;
                  end
               end
            end
            BLANK: begin
               if (cnt_q == '0) begin
                  state_q <= SHOW;
                  an_q    <= an_d;
                  seg_q   <= seg_d;
                  dpn_q   <= dpn_d;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign dp_n = dpn_q;

endmodule
